// File: rtl/sv_uart_rx_cfg_if.sv
`default_nettype none
// ============================================================================
// Module      : sv_uart_rx_cfg_if
// Description : AXI-Stream beat interface carrying received UART words.
//               tuser = {parity_err, frame_err} for the word on tdata.
// Revision    : 1.0 - initial release
// ============================================================================
interface sv_uart_rx_cfg_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [1:0]            tuser;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tuser, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/sv_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : sv_uart_rx_cfg
// Description : Configurable UART receiver (parity none/even/odd, 1/2 stop
//               bits) with glitch filter, false-start and break detection,
//               and a first-word-fall-through AXI-Stream output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module sv_uart_rx_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_PIPE    = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                               iclk,
  input  logic                               irst_n,
  input  logic                               irx,
  input  logic [DIV_WIDTH-1:0]               idivider,
  input  logic [1:0]                         iparity_mode,
  input  logic                               istop_bits,
  sv_uart_rx_cfg_if.master                   m_axis,
  output logic                               obreak,
  output logic                               ooverrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    ofifo_level
);

  localparam int c_LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int c_IDX_W  = $clog2(DATA_WIDTH);
  localparam int c_FLT_W  = $clog2(IN_PIPE + 1);
  localparam int c_WORD_W = DATA_WIDTH + 2;

  localparam logic [DIV_WIDTH-1:0] c_DIV_MIN  = DIV_WIDTH'(4);
  localparam logic [DIV_WIDTH-1:0] c_DIV_ONE  = DIV_WIDTH'(1);
  localparam logic [c_FLT_W-1:0]   c_FLT_LAST = c_FLT_W'(IN_PIPE - 1);
  localparam logic [c_FLT_W-1:0]   c_FLT_ONE  = c_FLT_W'(1);
  localparam logic [c_IDX_W-1:0]   c_IDX_LAST = c_IDX_W'(DATA_WIDTH - 1);
  localparam logic [c_IDX_W-1:0]   c_IDX_ONE  = c_IDX_W'(1);
  localparam logic [c_PTR_W-1:0]   c_PTR_ONE  = c_PTR_W'(1);
  localparam logic [c_LVL_W-1:0]   c_LVL_ONE  = c_LVL_W'(1);
  localparam logic [c_LVL_W-1:0]   c_LVL_FULL = c_LVL_W'(FIFO_DEPTH);

  localparam logic [2:0] c_S_IDLE     = 3'd0;
  localparam logic [2:0] c_S_START    = 3'd1;
  localparam logic [2:0] c_S_DATA     = 3'd2;
  localparam logic [2:0] c_S_PARITY   = 3'd3;
  localparam logic [2:0] c_S_STOP1    = 3'd4;
  localparam logic [2:0] c_S_STOP2    = 3'd5;
  localparam logic [2:0] c_S_BRK_WAIT = 3'd6;

  // Input conditioning
  logic [2:0]            r_sync;
  logic                  w_rx_s;
  logic                  r_rx_f;
  logic                  r_rx_f_d;
  logic [c_FLT_W-1:0]    r_flt_cnt;
  logic                  w_fall;

  // Bit timer and latched configuration
  logic [DIV_WIDTH-1:0]  r_cnt;
  logic                  r_first;
  logic [DIV_WIDTH-1:0]  r_div;
  logic [1:0]            r_par_mode;
  logic                  r_stop2;
  logic [DIV_WIDTH-1:0]  w_div_in;
  logic                  w_strobe;
  logic                  w_par_en;
  logic                  w_par_odd;

  // FSM and frame datapath
  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic                  w_start;
  logic                  w_shift_en;
  logic                  w_par_smp;
  logic                  w_stop1_smp;
  logic                  w_finish;
  logic                  w_is_break;
  logic                  w_frame_err;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [c_IDX_W-1:0]    r_bit_idx;
  logic                  r_par_err;
  logic                  r_par_low;
  logic                  r_stop1_low;

  // FIFO
  logic                  r_wr_en;
  logic [c_WORD_W-1:0]   r_wr_word;
  logic                  r_obreak;
  logic                  r_ovr;
  logic [c_WORD_W-1:0]   r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]    r_wptr;
  logic [c_PTR_W-1:0]    r_rptr;
  logic [c_LVL_W-1:0]    r_level;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_wr;

  assign w_rx_s = r_sync[2];
  assign w_fall = r_rx_f_d & ~r_rx_f;

  // Three-flop synchroniser for the asynchronous line; idles high
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) r_sync <= 3'b111;
    else         r_sync <= {r_sync[1:0], irx};
  end

  // Glitch filter: the filtered line follows only after IN_PIPE consecutive differing samples
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_rx_f    <= 1'b1;
      r_rx_f_d  <= 1'b1;
      r_flt_cnt <= '0;
    end else begin
      r_rx_f_d <= r_rx_f;
      if (w_rx_s == r_rx_f) begin
        r_flt_cnt <= '0;
      end else if (r_flt_cnt == c_FLT_LAST) begin
        r_rx_f    <= w_rx_s;
        r_flt_cnt <= '0;
      end else begin
        r_flt_cnt <= r_flt_cnt + c_FLT_ONE;
      end
    end
  end

  assign w_div_in  = (idivider < c_DIV_MIN) ? c_DIV_MIN : idivider;
  assign w_par_en  = (r_par_mode == 2'b01) || (r_par_mode == 2'b10);
  assign w_par_odd = (r_par_mode == 2'b10);
  // First strobe lands mid start bit, later ones one full bit apart
  assign w_strobe  = r_first ? (r_cnt == ((r_div >> 1) - c_DIV_ONE))
                             : (r_cnt == (r_div - c_DIV_ONE));
  assign w_start   = (r_state == c_S_IDLE) && w_fall;

  // Bit timer; configuration is captured at start detection and held for the frame
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_cnt      <= '0;
      r_first    <= 1'b0;
      r_div      <= c_DIV_MIN;
      r_par_mode <= 2'b00;
      r_stop2    <= 1'b0;
    end else if (w_start) begin
      r_cnt      <= '0;
      r_first    <= 1'b1;
      r_div      <= w_div_in;
      r_par_mode <= iparity_mode;
      r_stop2    <= istop_bits;
    end else if (w_strobe) begin
      r_cnt      <= '0;
      r_first    <= 1'b0;
    end else begin
      r_cnt      <= r_cnt + c_DIV_ONE;
    end
  end

  // Final frame error and break classification, evaluated on the last stop strobe
  assign w_frame_err = ~r_rx_f | ((r_state == c_S_STOP2) & r_stop1_low);
  assign w_is_break  = (r_shift == '0) && r_par_low && ~r_rx_f &&
                       ((r_state != c_S_STOP2) || r_stop1_low);

  // FSM state register
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) r_state <= c_S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE:     if (w_fall) w_state_nxt = c_S_START;
      c_S_START:    if (w_strobe) w_state_nxt = r_rx_f ? c_S_IDLE : c_S_DATA;
      c_S_DATA:     if (w_strobe && (r_bit_idx == c_IDX_LAST))
                      w_state_nxt = w_par_en ? c_S_PARITY : c_S_STOP1;
      c_S_PARITY:   if (w_strobe) w_state_nxt = c_S_STOP1;
      c_S_STOP1:    if (w_strobe) begin
                      if (r_stop2)         w_state_nxt = c_S_STOP2;
                      else if (w_is_break) w_state_nxt = c_S_BRK_WAIT;
                      else                 w_state_nxt = c_S_IDLE;
                    end
      c_S_STOP2:    if (w_strobe) w_state_nxt = w_is_break ? c_S_BRK_WAIT : c_S_IDLE;
      c_S_BRK_WAIT: if (r_rx_f) w_state_nxt = c_S_IDLE;
      default:      w_state_nxt = c_S_IDLE;
    endcase
  end

  // FSM outputs: per-state sample enables and the frame-complete strobe
  always_comb begin
    w_shift_en  = 1'b0;
    w_par_smp   = 1'b0;
    w_stop1_smp = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      c_S_DATA:   w_shift_en = w_strobe;
      c_S_PARITY: w_par_smp  = w_strobe;
      c_S_STOP1:  begin
                    w_stop1_smp = w_strobe;
                    w_finish    = w_strobe & ~r_stop2;
                  end
      c_S_STOP2:  w_finish = w_strobe;
      default:    ;
    endcase
  end

  // Frame datapath: LSB-first shift register, parity result and stop-bit history
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_par_err   <= 1'b0;
      r_par_low   <= 1'b1;
      r_stop1_low <= 1'b0;
    end else begin
      if (w_start) begin
        r_bit_idx   <= '0;
        r_par_err   <= 1'b0;
        r_par_low   <= 1'b1;
        r_stop1_low <= 1'b0;
      end
      if (w_shift_en) begin
        r_shift   <= {r_rx_f, r_shift[DATA_WIDTH-1:1]};
        r_bit_idx <= r_bit_idx + c_IDX_ONE;
      end
      if (w_par_smp) begin
        r_par_err <= (^r_shift) ^ r_rx_f ^ w_par_odd;
        r_par_low <= ~r_rx_f;
      end
      if (w_stop1_smp) r_stop1_low <= ~r_rx_f;
    end
  end

  // Register the completed word and break pulse one cycle after the final strobe
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_word <= '0;
      r_obreak  <= 1'b0;
    end else begin
      r_wr_en   <= w_finish & ~w_is_break;
      r_wr_word <= {r_par_err, w_frame_err, r_shift};
      r_obreak  <= w_finish & w_is_break;
    end
  end

  assign w_full  = (r_level == c_LVL_FULL);
  assign w_empty = (r_level == '0);
  assign w_pop   = ~w_empty & m_axis.tready;
  // A full FIFO still accepts a write when the head is leaving this cycle
  assign w_wr    = r_wr_en & (~w_full | w_pop);

  // Output FIFO storage, pointers, occupancy and overrun pulse
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= r_wr_word;
        r_wptr        <= r_wptr + c_PTR_ONE;
      end
      if (w_pop) r_rptr <= r_rptr + c_PTR_ONE;
      if (w_wr && !w_pop)      r_level <= r_level + c_LVL_ONE;
      else if (!w_wr && w_pop) r_level <= r_level - c_LVL_ONE;
      r_ovr <= r_wr_en & ~w_wr;
    end
  end

  assign m_axis.tvalid                 = ~w_empty;
  assign {m_axis.tuser, m_axis.tdata}  = r_mem[r_rptr];
  assign obreak                        = r_obreak;
  assign ooverrun                      = r_ovr;
  assign ofifo_level                   = r_level;

endmodule
`default_nettype wire

// File: tb/tb_sv_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_sv_uart_rx_cfg
// Description : Directed self-checking bench for sv_uart_rx_cfg.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sv_uart_rx_cfg;

  localparam int BIT = 16;

  logic        iclk = 1'b0;
  logic        irst_n = 1'b0;
  logic        irx = 1'b1;
  logic [15:0] idivider = 16'd16;
  logic [1:0]  iparity_mode = 2'b00;
  logic        istop_bits = 1'b0;
  logic        obreak;
  logic        ooverrun;
  logic [2:0]  ofifo_level;

  int checks = 0;
  int errors = 0;
  int n_brk = 0;
  int n_ovr = 0;
  logic [9:0] q_beats[$];

  sv_uart_rx_cfg_if #(.DATA_WIDTH(8)) axis ();

  sv_uart_rx_cfg #(
    .DATA_WIDTH(8), .IN_PIPE(5), .FIFO_DEPTH(4), .DIV_WIDTH(16)
  ) dut (
    .iclk(iclk), .irst_n(irst_n), .irx(irx), .idivider(idivider),
    .iparity_mode(iparity_mode), .istop_bits(istop_bits), .m_axis(axis),
    .obreak(obreak), .ooverrun(ooverrun), .ofifo_level(ofifo_level)
  );

  always #5 iclk = ~iclk;

  // Record accepted beats and count pulse cycles
  always @(negedge iclk) begin
    if (axis.tvalid && axis.tready) q_beats.push_back({axis.tuser, axis.tdata});
    if (obreak)   n_brk++;
    if (ooverrun) n_ovr++;
  end

  task automatic tx_bit(input logic v);
    irx = v;
    repeat (BIT) @(negedge iclk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_b,
                            input logic s1, input logic two, input logic s2);
    tx_bit(1'b0);
    for (int i = 0; i < 8; i++) tx_bit(d[i]);
    if (par_en) tx_bit(par_b);
    tx_bit(s1);
    if (two) tx_bit(s2);
    irx = 1'b1;
    repeat (3 * BIT) @(negedge iclk);
  endtask

  task automatic set_tready(input logic v);
    @(posedge iclk);
    #1 axis.tready = v;
    @(negedge iclk);
  endtask

  task automatic test_reset;
    axis.tready = 1'b1;
    irst_n = 1'b0;
    repeat (3) @(negedge iclk);
    checks++;
    if ({axis.tvalid, obreak, ooverrun} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {axis.tvalid, obreak, ooverrun});
    end
    checks++;
    if (axis.tdata !== 8'h00) begin
      errors++; $display("FAIL reset_tdata: got %h expected 00", axis.tdata);
    end
    checks++;
    if (axis.tuser !== 2'b00) begin
      errors++; $display("FAIL reset_tuser: got %b expected 00", axis.tuser);
    end
    checks++;
    if (ofifo_level !== 3'd0) begin
      errors++; $display("FAIL reset_level: got %0d expected 0", ofifo_level);
    end
    irst_n = 1'b1;
    repeat (2 * BIT) @(negedge iclk);
  endtask

  task automatic test_8n1;
    logic [7:0] d;
    d = 8'hA5;
    tx_bit(1'b0);
    for (int i = 0; i < 8; i++) tx_bit(d[i]);
    irx = 1'b1;
    // Stop strobe is 16 cycles into the stop bit; the beat shows 2 cycles later
    for (int k = 1; k <= 18; k++) begin
      @(negedge iclk);
      if (k == 17) begin
        checks++;
        if (axis.tvalid !== 1'b0) begin
          errors++; $display("FAIL 8n1_early_valid: got %b expected 0", axis.tvalid);
        end
      end
      if (k == 18) begin
        checks++;
        if (axis.tvalid !== 1'b1) begin
          errors++; $display("FAIL 8n1_valid: got %b expected 1", axis.tvalid);
        end
        checks++;
        if ({axis.tuser, axis.tdata} !== {2'b00, 8'hA5}) begin
          errors++; $display("FAIL 8n1_beat: got %b_%h expected 00_a5", axis.tuser, axis.tdata);
        end
      end
    end
    @(negedge iclk);
    checks++;
    if ({axis.tvalid, ofifo_level} !== 4'b0_000) begin
      errors++; $display("FAIL 8n1_drain: got valid=%b level=%0d expected 0/0", axis.tvalid, ofifo_level);
    end
    repeat (2 * BIT) @(negedge iclk);
    q_beats.delete();
  endtask

  task automatic test_parity;
    logic [9:0] w;
    iparity_mode = 2'b01;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (q_beats.size() != 1) begin
      errors++; $display("FAIL even_count: got %0d expected 1", q_beats.size());
    end
    w = (q_beats.size() > 0) ? q_beats.pop_front() : 10'bx;
    checks++;
    if (w !== {2'b10, 8'h3C}) begin
      errors++; $display("FAIL even_beat: got %b expected 1000111100", w);
    end
    iparity_mode = 2'b10;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    w = (q_beats.size() > 0) ? q_beats.pop_front() : 10'bx;
    checks++;
    if (w !== {2'b00, 8'h3C}) begin
      errors++; $display("FAIL odd_beat: got %b expected 0000111100", w);
    end
    iparity_mode = 2'b00;
    q_beats.delete();
  endtask

  task automatic test_stop2;
    logic [9:0] w;
    istop_bits = 1'b1;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    w = (q_beats.size() > 0) ? q_beats.pop_front() : 10'bx;
    checks++;
    if (w !== {2'b01, 8'h55}) begin
      errors++; $display("FAIL stop2_err_beat: got %b expected 0101010101", w);
    end
    send_frame(8'h12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    w = (q_beats.size() > 0) ? q_beats.pop_front() : 10'bx;
    checks++;
    if (w !== {2'b00, 8'h12}) begin
      errors++; $display("FAIL stop2_ok_beat: got %b expected 0000010010", w);
    end
    istop_bits = 1'b0;
    q_beats.delete();
  endtask

  task automatic test_glitch;
    int b0;
    logic [9:0] w;
    b0 = n_brk;
    irx = 1'b0;
    repeat (2) @(negedge iclk);
    irx = 1'b1;
    repeat (3 * BIT) @(negedge iclk);
    checks++;
    if (q_beats.size() != 0) begin
      errors++; $display("FAIL glitch_2clk: got %0d beats expected 0", q_beats.size());
    end
    irx = 1'b0;
    repeat (6) @(negedge iclk);
    irx = 1'b1;
    repeat (3 * BIT) @(negedge iclk);
    checks++;
    if ((q_beats.size() != 0) || (n_brk != b0)) begin
      errors++; $display("FAIL false_start: got beats=%0d breaks=%0d expected 0/0", q_beats.size(), n_brk - b0);
    end
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    w = (q_beats.size() > 0) ? q_beats.pop_front() : 10'bx;
    checks++;
    if (w !== {2'b00, 8'h5A}) begin
      errors++; $display("FAIL after_glitch_beat: got %b expected 0001011010", w);
    end
    q_beats.delete();
  endtask

  task automatic test_break;
    int b0;
    logic [9:0] w;
    b0 = n_brk;
    irx = 1'b0;
    repeat (12 * BIT) @(negedge iclk);
    irx = 1'b1;
    repeat (3 * BIT) @(negedge iclk);
    checks++;
    if (n_brk - b0 != 1) begin
      errors++; $display("FAIL break_pulse: got %0d cycles expected 1", n_brk - b0);
    end
    checks++;
    if (q_beats.size() != 0) begin
      errors++; $display("FAIL break_nopush: got %0d beats expected 0", q_beats.size());
    end
    send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    w = (q_beats.size() > 0) ? q_beats.pop_front() : 10'bx;
    checks++;
    if (w !== {2'b00, 8'h7E}) begin
      errors++; $display("FAIL after_break_beat: got %b expected 0001111110", w);
    end
    q_beats.delete();
  endtask

  task automatic test_overrun;
    int o0;
    set_tready(1'b0);
    o0 = n_ovr;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if ((ofifo_level !== 3'd4) || (n_ovr != o0)) begin
      errors++; $display("FAIL fill4: got level=%0d ovr=%0d expected 4/0", ofifo_level, n_ovr - o0);
    end
    send_frame(8'h05, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (n_ovr - o0 != 1) begin
      errors++; $display("FAIL overrun_pulse: got %0d expected 1", n_ovr - o0);
    end
    checks++;
    if ({ofifo_level, axis.tvalid, axis.tdata} !== {3'd4, 1'b1, 8'h01}) begin
      errors++; $display("FAIL overrun_hold: got level=%0d valid=%b data=%h expected 4/1/01",
                         ofifo_level, axis.tvalid, axis.tdata);
    end
    @(posedge iclk);
    #1 axis.tready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge iclk);
      checks++;
      if ({axis.tvalid, axis.tdata} !== {1'b1, 8'(i)}) begin
        errors++; $display("FAIL drain_beat%0d: got valid=%b data=%h expected 1/%h", i, axis.tvalid, axis.tdata, 8'(i));
      end
    end
    @(negedge iclk);
    checks++;
    if ({axis.tvalid, ofifo_level} !== 4'b0_000) begin
      errors++; $display("FAIL drain_empty: got valid=%b level=%0d expected 0/0", axis.tvalid, ofifo_level);
    end
    q_beats.delete();
  endtask

  task automatic test_reset_mid;
    set_tready(1'b0);
    send_frame(8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (ofifo_level !== 3'd1) begin
      errors++; $display("FAIL pre_reset_level: got %0d expected 1", ofifo_level);
    end
    tx_bit(1'b0);
    tx_bit(1'b1);
    tx_bit(1'b1);
    tx_bit(1'b0);
    irst_n = 1'b0;
    irx = 1'b1;
    #1;
    checks++;
    if ({axis.tvalid, ofifo_level, axis.tdata} !== {1'b0, 3'd0, 8'h00}) begin
      errors++; $display("FAIL reset_mid_out: got valid=%b level=%0d data=%h expected 0/0/00",
                         axis.tvalid, ofifo_level, axis.tdata);
    end
    repeat (4) @(negedge iclk);
    axis.tready = 1'b1;
    irst_n = 1'b1;
    q_beats.delete();
    repeat (20 * BIT) @(negedge iclk);
    checks++;
    if ((q_beats.size() != 0) || (axis.tvalid !== 1'b0)) begin
      errors++; $display("FAIL reset_mid_nobeat: got beats=%0d valid=%b expected 0/0", q_beats.size(), axis.tvalid);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_stop2();
    test_glitch();
    test_break();
    test_overrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
